// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one 12-bit sample per valid/ready handshake into a
// 16-bit MCP4921-style SPI frame {CTRL, sample}, MSB first, SPI mode 0.
// Frame sequence: IDLE -> SHIFT (16 bits) -> TAIL -> GAP [-> LATCH] -> IDLE.
// Optional feature macro: DAC_SPI_LDAC_PULSE_EN
//   defined   : LATCH state present; ldac_n pulses low for CLK_DIV cycles
//               right after GAP, so the DAC output updates on that pulse.
//   undefined : no LATCH state; ldac_n tied low, so the DAC output updates
//               on the cs_n rise.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  CTRL    = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic        ldac_n,
  output logic        frame_done
);

  // Reload value of the half-period down-counter (counts CLK_DIV-1 .. 0).
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  // With CLK_DIV=1 the final state is a single cycle, so frame_done must be
  // raised on the transition into it rather than from inside it.
  localparam logic FD_ON_ENTRY = (CLK_DIV == 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    TAIL  = 3'd2,
    GAP   = 3'd3
`ifdef DAC_SPI_LDAC_PULSE_EN
    ,
    LATCH = 3'd4
`endif
  } state_t;

  state_t      state;
  logic [7:0]  hcnt;   // clk cycles left in the current half period / phase
  logic [3:0]  bcnt;   // index of the bit currently on mosi
  logic [14:0] shreg;  // bits still to be sent after the one on mosi

  logic accept;
  logic shift_en;

  assign sample_ready = (state == IDLE);
  assign accept       = sample_valid && sample_ready && !rst;
  // The register advances on every sclk high-to-low transition that is not
  // the end of the last bit.
  assign shift_en     = (state == SHIFT) && (hcnt == 8'd0) && sclk && (bcnt != 4'd0);

  // Frame datapath: load the low 15 frame bits on accept, shift on sclk fall.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= {CTRL[2:0], sample_in};
    end else if (shift_en) begin
      shreg <= {shreg[13:0], 1'b0};
    end
  end

`ifndef DAC_SPI_LDAC_PULSE_EN
  // Without the latch pulse the DAC transfers on the cs_n rise.
  assign ldac_n = 1'b0;
`endif

  // Frame sequencer with registered SPI outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= 8'd0;
      bcnt       <= 4'd0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DAC_SPI_LDAC_PULSE_EN
      ldac_n     <= 1'b1;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid && sample_ready) begin
            state <= SHIFT;
            cs_n  <= 1'b0;
            sclk  <= 1'b0;
            mosi  <= CTRL[3];
            hcnt  <= HALF_LAST;
            bcnt  <= 4'd15;
          end
        end

        SHIFT: begin
          if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            hcnt <= HALF_LAST;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bcnt == 4'd0) begin
                // Last bit's high phase done; mosi holds until cs_n rises.
                state <= TAIL;
              end else begin
                bcnt <= bcnt - 4'd1;
                mosi <= shreg[14];
              end
            end
          end
        end

        TAIL: begin
          if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            state <= GAP;
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
            hcnt  <= HALF_LAST;
`ifndef DAC_SPI_LDAC_PULSE_EN
            frame_done <= FD_ON_ENTRY;
`endif
          end
        end

`ifdef DAC_SPI_LDAC_PULSE_EN
        GAP: begin
          if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            state      <= LATCH;
            ldac_n     <= 1'b0;
            hcnt       <= HALF_LAST;
            frame_done <= FD_ON_ENTRY;
          end
        end

        LATCH: begin
          if (hcnt != 8'd0) begin
            hcnt       <= hcnt - 8'd1;
            frame_done <= (hcnt == 8'd1);
          end else begin
            state  <= IDLE;
            ldac_n <= 1'b1;
          end
        end
`else
        GAP: begin
          if (hcnt != 8'd0) begin
            hcnt       <= hcnt - 8'd1;
            frame_done <= (hcnt == 8'd1);
          end else begin
            state <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: two dac_spi_tx instances (CLK_DIV=2 and CLK_DIV=1) with a
// per-instance scoreboard. Expected frames are queued at each handshake and
// compared against the bits captured on sclk rises when cs_n goes high.
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_PULSE_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [1:0]  sclk;
  logic [1:0]  cs_n;
  logic [1:0]  mosi;
  logic [1:0]  ldac_n;
  logic [1:0]  fdone;
  logic [11:0] sin [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV  = (g == 0) ? 2 : 1;
    localparam int BUSY = (MAC ? 35 : 34) * DIV;

    dac_spi_tx #(.CLK_DIV(DIV), .CTRL(4'b0011)) dut (
      .clk         (clk),
      .rst         (rst[g]),
      .sample_in   (sin[g]),
      .sample_valid(valid[g]),
      .sample_ready(ready[g]),
      .sclk        (sclk[g]),
      .cs_n        (cs_n[g]),
      .mosi        (mosi[g]),
      .ldac_n      (ldac_n[g]),
      .frame_done  (fdone[g])
    );

    logic [15:0] exp_q[$];
    int          hs_t[$];
    logic [15:0] shv = '0;
    int nbits = 0, cs_low = 0, rdy_low = 0, ld_low = 0, ld_bad = 0;
    int hi_run = 0, lo_run = 0, fd_cnt = 0, viol = 0, frames = 0;
    logic p_sclk = 1'b0, p_cs = 1'b1, p_rdy = 1'b1, p_fd = 1'b0, p_mosi = 1'b0;

    always @(negedge clk) begin
      if (rst[g]) begin
        exp_q.delete();
        shv = '0; nbits = 0; cs_low = 0; rdy_low = 0; ld_low = 0; ld_bad = 0;
        hi_run = 0; lo_run = 0; fd_cnt = 0;
      end else begin
        if (valid[g] && ready[g]) begin
          exp_q.push_back({4'b0011, sin[g]});
          hs_t.push_back(cyc);
        end
        if (sclk[g] && !p_sclk) begin
          if (cs_n[g]) viol++;
          else begin
            shv = {shv[14:0], mosi[g]};
            nbits++;
          end
          if (lo_run != DIV) viol++;
          lo_run = 0;
        end
        if (!sclk[g] && p_sclk) begin
          if (hi_run != DIV) viol++;
          hi_run = 0;
        end
        if (sclk[g] && (mosi[g] !== p_mosi)) viol++;
        if (!cs_n[g] && p_cs) lo_run = 0;
        if (sclk[g]) hi_run++;
        else if (!cs_n[g]) lo_run++;
        if (!cs_n[g]) cs_low++;
        if (!ready[g]) rdy_low++;
        if (fdone[g]) fd_cnt++;
`ifdef DAC_SPI_LDAC_PULSE_EN
        if (!ldac_n[g]) ld_low++;
`else
        if (ldac_n[g]) ld_bad++;
`endif
        if (cs_n[g] && !p_cs) begin
          chk($sformatf("u%0d_cs_low", g), cs_low, 33 * DIV);
          chk($sformatf("u%0d_nbits", g), nbits, 16);
          chk($sformatf("u%0d_q_size", g), exp_q.size(), 1);
          if (exp_q.size() != 0) chk($sformatf("u%0d_frame", g), shv, exp_q.pop_front());
          frames++;
          cs_low = 0;
          nbits  = 0;
        end
        if (ready[g] && !p_rdy) begin
          chk($sformatf("u%0d_busy", g), rdy_low, BUSY);
          chk($sformatf("u%0d_fdone_cnt", g), fd_cnt, 1);
          chk($sformatf("u%0d_fdone_last", g), p_fd, 1);
`ifdef DAC_SPI_LDAC_PULSE_EN
          chk($sformatf("u%0d_ldac_low", g), ld_low, DIV);
`else
          chk($sformatf("u%0d_ldac_const", g), ld_bad, 0);
`endif
          rdy_low = 0; fd_cnt = 0; ld_low = 0; ld_bad = 0;
        end
      end
      p_sclk = sclk[g];
      p_cs   = cs_n[g];
      p_rdy  = ready[g];
      p_fd   = fdone[g];
      p_mosi = mosi[g];
    end
  end

  task automatic send(input int g, input logic [11:0] v);
    int n = 0;
    while (!ready[g] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", ready[g], 1);
    sin[g]   = v;
    valid[g] = 1'b1;
    @(posedge clk); #1;
    valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (!ready[g] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", ready[g], 1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, stall_bad, len, p, period0, period1;
    period0 = (MAC ? 35 : 34) * 2 + 1;
    period1 = (MAC ? 35 : 34) * 1 + 1;
    rst = 2'b11; valid = 2'b00; sin[0] = '0; sin[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",  cs_n,   2'b11);
    chk("rst_sclk",  sclk,   2'b00);
    chk("rst_mosi",  mosi,   2'b00);
    chk("rst_fdone", fdone,  2'b00);
    chk("rst_ready", ready,  2'b11);
    chk("rst_ldac",  ldac_n, MAC ? 2'b11 : 2'b00);
    rst = 2'b00;
    @(posedge clk); #1;

    // Single frame and accept-to-first-edge timing on the CLK_DIV=2 unit.
    send(0, 12'h7FC);
    chk("t1_cs_n", cs_n[0], 0);
    chk("t1_sclk", sclk[0], 0);
    chk("t1_mosi", mosi[0], 0);
    @(posedge clk); #1;
    chk("t2_sclk_low", sclk[0], 0);
    @(posedge clk); #1;
    chk("t3_sclk_rise", sclk[0], 1);
    wait_idle(0);

    // Boundary samples.
    send(0, 12'h000);
    wait_idle(0);
    send(0, 12'hFFF);
    wait_idle(0);

    // Continuous valid with a stepping sample.
    u[0].hs_t.delete();
    sin[0]   = 12'h100;
    valid[0] = 1'b1;
    len = 4 * period0 - 10;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      sin[0] = sin[0] + 12'd37;
    end
    valid[0] = 1'b0;
    wait_idle(0);
    chk("hs_count0", u[0].hs_t.size(), 4);
    for (int i = 1; i < u[0].hs_t.size(); i++)
      chk("hs_gap0", u[0].hs_t[i] - u[0].hs_t[i-1], period0);

    // Reset on the 7th sclk rise of a frame.
    send(0, 12'h5A3);
    n = 0; k = 0; p = sclk[0];
    while (n < 7 && k < 1000) begin
      @(posedge clk); #1;
      if (sclk[0] && !p) n++;
      p = sclk[0];
      k++;
    end
    chk("rise7", n, 7);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cs_n",  cs_n[0],   1);
    chk("mid_rst_sclk",  sclk[0],   0);
    chk("mid_rst_mosi",  mosi[0],   0);
    chk("mid_rst_fdone", fdone[0],  0);
    chk("mid_rst_ldac",  ldac_n[0], MAC ? 1 : 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    send(0, 12'hA5C);
    wait_idle(0);

    // Stall: no valid for 200 cycles.
    stall_bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (!ready[0] || !cs_n[0] || sclk[0] || mosi[0]) stall_bad++;
    end
    chk("stall_idle", stall_bad, 0);

    // CLK_DIV=1 unit.
    send(1, 12'h123);
    wait_idle(1);
    send(1, 12'hFFF);
    wait_idle(1);
    u[1].hs_t.delete();
    sin[1]   = 12'h800;
    valid[1] = 1'b1;
    len = 2 * period1 - 5;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      sin[1] = sin[1] + 12'd5;
    end
    valid[1] = 1'b0;
    wait_idle(1);
    chk("hs_count1", u[1].hs_t.size(), 2);
    if (u[1].hs_t.size() == 2) chk("hs_gap1", u[1].hs_t[1] - u[1].hs_t[0], period1);

    chk("viol0",   u[0].viol, 0);
    chk("viol1",   u[1].viol, 0);
    chk("frames0", u[0].frames, 8);
    chk("frames1", u[1].frames, 4);
    chk("q_left0", u[0].exp_q.size(), 0);
    chk("q_left1", u[1].exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial DAC transmitter that sits directly downstream of the 12-bit triangular wave generator. It accepts one 12-bit unsigned sample per valid/ready handshake and shifts it out as a 16-bit MCP4921-style SPI frame: 4 control bits, then 12 data bits, MSB first. It produces SCLK, CS_n, MOSI and LDAC_n for the external DAC. The generator updates faster than one frame can be sent, so `sample_valid` is tied high and the block decimates by taking a new sample whenever it is ready.

## Interface
- `CLK_DIV`, default 2: half-period of `sclk`, counted in `clk` cycles. Legal values are 1 to 255. 2 at 12 MHz gives a 3 MHz SCLK.
- `CTRL`, default 4'b0011: frame bits [15:12], {A/B, BUF, GA_n, SHDN_n}. The default is channel A, unbuffered, 1x gain, active.
- `clk`  in  1  system clock, 12 MHz.
- `rst`  in  1  synchronous reset, active-high.
- `sample_in`  in  12  sample to transmit. It is captured only on a handshake.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  high only in IDLE. This is a combinational decode of the state.
- `sclk`  out  1  SPI clock, mode 0, idles low.
- `cs_n`  out  1  frame select, active-low.
- `mosi`  out  1  serial data. It changes only while `sclk` is low.
- `ldac_n`  out  1  DAC latch strobe, active-low.
- `frame_done`  out  1  one-cycle pulse on the last cycle of a frame.

## Operation
- States and their outputs:
  - IDLE: `cs_n`=1, `sclk`=0, `mosi`=0.
  - SHIFT: `cs_n`=0.
  - TAIL: `cs_n`=0, `sclk`=0.
  - GAP: `cs_n`=1.
  - LATCH: `ldac_n`=0. This state exists only when the macro is defined.
- IDLE: when `sample_valid` and `sample_ready` are both high, the shift register loads {CTRL, sample_in}. The bit counter loads 15 and the state goes to SHIFT.
- SHIFT, per bit:
  - `mosi` = shreg[15].
  - `sclk` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - On the high-to-low transition the register shifts left and the bit counter decrements.
  - After bit 0's high phase the state goes to TAIL.
- TAIL: lasts `CLK_DIV` cycles, then the state goes to GAP.
- GAP: lasts `CLK_DIV` cycles. The DAC input register latches on this `cs_n` rise. The next state is LATCH if the macro is defined, otherwise IDLE.
- LATCH: lasts `CLK_DIV` cycles, then the state goes to IDLE.
- `frame_done` is high in the last cycle of the final state, i.e. the cycle before IDLE.
- Arithmetic: the half-period counter is 8 bits and counts `CLK_DIV-1` down to 0. The bit counter is 4 bits and does not wrap past 0.
- `sample_in` changes while `sample_ready`=0 are ignored. The frame in flight is never corrupted.
- A `sample_valid` held high gives back-to-back frames. IDLE then lasts exactly 1 cycle between frames.
- Reset at any point, including mid-frame:
  - State goes to IDLE; `cs_n`=1, `sclk`=0, `mosi`=0, `ldac_n`=1, `frame_done`=0.
  - The partial frame is abandoned; no `ldac_n` pulse is issued.
  - Handshakes are ignored while `rst`=1.

## Timing
- All outputs are registered except `sample_ready`.
- Accept at cycle T: `cs_n` falls and `mosi` = bit 15 at T+1, with `sclk` low.
- First `sclk` rise is at T+1+`CLK_DIV`.
- `cs_n` low duration: 33·`CLK_DIV` cycles (32 for SHIFT, 1 for TAIL).
- Busy duration (`sample_ready`=0): 34·`CLK_DIV` cycles without the macro, 35·`CLK_DIV` with it.
- Frame period under continuous valid: busy + 1. With `CLK_DIV`=2 and the macro on, this is 71 cycles, about 169 kS/s.

## Configuration
- `DAC_SPI_LDAC_PULSE_EN` defined:
  - The LATCH state exists.
  - `ldac_n` is 1 everywhere except a `CLK_DIV`-cycle low pulse that starts right after GAP.
  - The DAC output updates on that pulse.
- Not defined:
  - The LATCH state is removed.
  - `ldac_n` is constant 0, so the DAC output updates on the `cs_n` rise.
  - GAP goes straight to IDLE.

## Test plan
- Single frame: `CLK_DIV`=2, macro on, one handshake with `sample_in`=12'h7FC.
  - MOSI sampled on `sclk` rises = 16'h37FC, MSB first.
  - `cs_n` low for 66 cycles; `sample_ready` low for 70; one `frame_done`; `ldac_n` low for 2 cycles.
- Continuous valid with `sample_in` stepping each cycle, `CLK_DIV`=2:
  - Handshakes occur exactly 71 cycles apart.
  - Each frame carries the value present on its accept cycle.
- Boundaries: `sample_in`=12'h000 and 12'hFFF give frames 16'h3000 and 16'h3FFF. No extra `sclk` edges appear.
- Reset at `sclk` rise number 7:
  - Next cycle: `cs_n`=1, `sclk`=0, `mosi`=0, `ldac_n`=1.
  - The next frame after reset is complete and correct.
- Macro off, `CLK_DIV`=1:
  - `ldac_n`=0 constantly; `cs_n` low for 33 cycles; `sample_ready` low for 34.
  - `sclk` is high and low one cycle each.
- Stall: `sample_valid`=0 for 200 cycles. `cs_n`, `sclk` and `mosi` stay idle and `sample_ready` stays 1.
